// File: rtl/fix_pkg.sv
// -----------------------------------------------------------------------------
// fix_pkg
// Shared definitions for the FIX byte parser and the field decoder: protocol
// byte constants, the decoder FSM state type, field error bit positions and a
// small digit classification helper.
// -----------------------------------------------------------------------------
package fix_pkg;

    localparam logic [7:0] SOH_C  = 8'h01;  // field terminator
    localparam logic [7:0] SEP_C  = 8'h3D;  // '=' between tag and value
    localparam logic [7:0] ZERO_C = 8'h30;  // '0'
    localparam logic [7:0] NINE_C = 8'h39;  // '9'

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_VAL  = 2'd2
    } state_e;

    // Bit positions inside the 3-bit field error vector {trunc, tag_ovf, bad_tag}.
    localparam int ERR_BAD_TAG = 0;
    localparam int ERR_TAG_OVF = 1;
    localparam int ERR_TRUNC   = 2;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO_C) && (b <= NINE_C);
    endfunction

endpackage

// File: rtl/fix_field_decoder_if.sv
// -----------------------------------------------------------------------------
// fix_field_decoder_if
// Field record channel between the decoder (master) and the message-level
// consumer (slave). A record is transferred on a cycle with valid & ready.
//   fld_valid_o  record valid                 (master -> slave)
//   fld_ready_i  consumer accepts record      (slave  -> master)
//   fld_tag_o    binary tag number
//   fld_len_o    stored value byte count
//   fld_val_o    value bytes, byte k at [8k+7:8k], unused bytes zero
//   fld_err_o    {trunc, tag_ovf, bad_tag}
// -----------------------------------------------------------------------------
interface fix_field_decoder_if #(
    parameter int TAG_W   = 16,
    parameter int MAX_VAL = 32,
    parameter int LEN_W   = 6
);
    logic                   fld_valid_o;
    logic                   fld_ready_i;
    logic [TAG_W-1:0]       fld_tag_o;
    logic [LEN_W-1:0]       fld_len_o;
    logic [8*MAX_VAL-1:0]   fld_val_o;
    logic [2:0]             fld_err_o;

    modport master (
        output fld_valid_o, fld_tag_o, fld_len_o, fld_val_o, fld_err_o,
        input  fld_ready_i
    );

    modport slave (
        input  fld_valid_o, fld_tag_o, fld_len_o, fld_val_o, fld_err_o,
        output fld_ready_i
    );
endinterface

// File: rtl/fix_tag_accum.sv
// -----------------------------------------------------------------------------
// fix_tag_accum
// ASCII decimal accumulator for FIX tag numbers.
//   clk, rst   clock, synchronous active-high reset
//   clr_i      restart from zero (applies before en_i in the same cycle)
//   en_i       accumulate data_i
//   data_i     tag byte
//   tag_o      accumulated value, saturates at all-ones
//   bad_o      a non-digit byte was seen
//   ovf_o      the value exceeded 2**TAG_W-1 at some point
//   ndig_o     number of digit bytes seen (saturating)
// -----------------------------------------------------------------------------
module fix_tag_accum
    import fix_pkg::*;
#(
    parameter int TAG_W = 16,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [7:0]       data_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             bad_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] ndig_o
);

    // tag*10 + 9 always fits in TAG_W+4 bits, so overflow is visible in the top bits.
    localparam int PROD_W = TAG_W + 4;

    logic [TAG_W-1:0]  tag_q, tag_d, tag_base;
    logic              bad_q, bad_d, bad_base;
    logic              ovf_q, ovf_d, ovf_base;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
    logic [PROD_W-1:0] prod;

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first; a
        // missing default would infer a latch.
        tag_base = clr_i ? '0   : tag_q;
        bad_base = clr_i ? 1'b0 : bad_q;
        ovf_base = clr_i ? 1'b0 : ovf_q;
        cnt_base = clr_i ? '0   : cnt_q;
        tag_d    = tag_base;
        bad_d    = bad_base;
        ovf_d    = ovf_base;
        cnt_d    = cnt_base;
        prod     = '0;
        if (en_i) begin
            if (is_digit(data_i)) begin
                prod = PROD_W'(tag_base) * PROD_W'(10) + PROD_W'(data_i - ZERO_C);
                if (prod[PROD_W-1:TAG_W] != '0) begin
                    tag_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    tag_d = prod[TAG_W-1:0];
                end
                if (cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
            end else begin
                // Non-digit: flag it and leave the running value untouched.
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            tag_q <= '0;
            bad_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            bad_q <= bad_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign tag_o  = tag_q;
    assign bad_o  = bad_q;
    assign ovf_o  = ovf_q;
    assign ndig_o = cnt_q;

endmodule

// File: rtl/fix_field_decoder.sv
// -----------------------------------------------------------------------------
// fix_field_decoder
// Turns the FIX parser's tag/value byte stream into one record per field.
//   clk, rst        clock, synchronous active-high reset
//   data_i          byte from parser
//   tag_s_i         data_i is a tag byte
//   tag_e_i         '=' seen (data_i ignored)
//   value_s_i       data_i is a value byte
//   value_e_i       SOH seen (data_i ignored); commits the field
//   fld             record channel (master side)
//   drop_cnt_o      saturating count of discarded fields
// Assembly (accumulator + value buffer) is separate from the output register,
// so parsing continues while a record waits for the consumer.
// -----------------------------------------------------------------------------
module fix_field_decoder
    import fix_pkg::*;
#(
    parameter int TAG_W   = 16,
    parameter int MAX_VAL = 32,
    parameter int LEN_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_i,
    input  logic              tag_s_i,
    input  logic              tag_e_i,
    input  logic              value_s_i,
    input  logic              value_e_i,
    fix_field_decoder_if.master fld,
    output logic [15:0]       drop_cnt_o
);

    localparam int IDX_W = $clog2(8 * MAX_VAL);

    state_e state_q, state_d;
    logic   multi_strobe;
    logic   start_tag, acc_tag, store_val, commit, proto_err;

    logic [TAG_W-1:0] acc_tag_w;
    logic             acc_bad_w, acc_ovf_w;
    logic [2:0]       acc_ndig_w;

    logic [8*MAX_VAL-1:0] val_q, val_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 trunc_q, trunc_d;
    logic [IDX_W-1:0]     wr_idx;

    logic                 fld_valid_q, fld_valid_d;
    logic [TAG_W-1:0]     fld_tag_q, fld_tag_d;
    logic [LEN_W-1:0]     fld_len_q, fld_len_d;
    logic [8*MAX_VAL-1:0] fld_val_q, fld_val_d;
    logic [2:0]           fld_err_q, fld_err_d;
    logic                 out_free, load, drop_evt;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    assign multi_strobe = $countones({tag_s_i, tag_e_i, value_s_i, value_e_i}) > 1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state. Any protocol error returns to IDLE, except a lone tag
    // byte in VAL, which abandons the field and starts a new tag.
    always_comb begin
        state_d = state_q;
        if (multi_strobe) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (tag_s_i) state_d = ST_TAG;
                ST_TAG: begin
                    if (tag_e_i)                     state_d = ST_VAL;
                    else if (value_s_i || value_e_i) state_d = ST_IDLE;
                end
                ST_VAL: begin
                    if (value_e_i || tag_e_i) state_d = ST_IDLE;
                    else if (tag_s_i)         state_d = ST_TAG;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: datapath controls
    always_comb begin
        start_tag = 1'b0;
        acc_tag   = 1'b0;
        store_val = 1'b0;
        commit    = 1'b0;
        proto_err = 1'b0;
        if (multi_strobe) begin
            proto_err = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_tag = tag_s_i;
                    proto_err = tag_e_i | value_s_i | value_e_i;
                end
                ST_TAG: begin
                    acc_tag   = tag_s_i;
                    proto_err = value_s_i | value_e_i;
                end
                ST_VAL: begin
                    store_val = value_s_i;
                    commit    = value_e_i;
                    start_tag = tag_s_i;
                    proto_err = tag_s_i | tag_e_i;
                end
                default: proto_err = 1'b0;
            endcase
        end
    end

    fix_tag_accum #(.TAG_W(TAG_W), .CNT_W(3)) u_tag_accum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_tag),
        .en_i   (start_tag | acc_tag),
        .data_i (data_i),
        .tag_o  (acc_tag_w),
        .bad_o  (acc_bad_w),
        .ovf_o  (acc_ovf_w),
        .ndig_o (acc_ndig_w)
    );

    // Value buffer: cleared at the first tag byte so unused bytes read as zero.
    assign wr_idx = IDX_W'({len_q, 3'b000});

    always_comb begin
        val_d   = val_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        if (start_tag) begin
            val_d   = '0;
            len_d   = '0;
            trunc_d = 1'b0;
        end else if (store_val) begin
            if (len_q < LEN_W'(MAX_VAL)) begin
                val_d[wr_idx +: 8] = data_i;
                len_d              = len_q + LEN_W'(1);
            end else begin
                trunc_d = 1'b1;
            end
        end
    end

    // Output register loads when empty or being drained this cycle.
    assign out_free = !fld_valid_q || fld.fld_ready_i;
    assign load     = commit && out_free;
    assign drop_evt = proto_err || (commit && !out_free);

    always_comb begin
        fld_valid_d = fld_valid_q;
        fld_tag_d   = fld_tag_q;
        fld_len_d   = fld_len_q;
        fld_val_d   = fld_val_q;
        fld_err_d   = fld_err_q;
        if (load) begin
            fld_valid_d            = 1'b1;
            fld_tag_d              = acc_tag_w;
            fld_len_d              = len_q;
            fld_val_d              = val_q;
            fld_err_d[ERR_TRUNC]   = trunc_q;
            fld_err_d[ERR_TAG_OVF] = acc_ovf_w;
            // A tag with no digits at all is just as unusable as one with junk.
            fld_err_d[ERR_BAD_TAG] = acc_bad_w || (acc_ndig_w == '0);
        end else if (fld.fld_ready_i) begin
            fld_valid_d = 1'b0;
        end
    end

    assign drop_cnt_d = (drop_evt && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: the value buffer and output record are reset on purpose: idle
        // outputs and unused value bytes must read as zero, not stale data.
        if (rst) begin
            val_q       <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            fld_valid_q <= 1'b0;
            fld_tag_q   <= '0;
            fld_len_q   <= '0;
            fld_val_q   <= '0;
            fld_err_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            val_q       <= val_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            fld_valid_q <= fld_valid_d;
            fld_tag_q   <= fld_tag_d;
            fld_len_q   <= fld_len_d;
            fld_val_q   <= fld_val_d;
            fld_err_q   <= fld_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fld.fld_valid_o = fld_valid_q;
    assign fld.fld_tag_o   = fld_tag_q;
    assign fld.fld_len_o   = fld_len_q;
    assign fld.fld_val_o   = fld_val_q;
    assign fld.fld_err_o   = fld_err_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_fix_field_decoder.sv
// -----------------------------------------------------------------------------
// tb_fix_field_decoder
// Drives parser-style byte streams into fix_field_decoder. Expected records are
// queued when a field is sent and compared when the DUT hands one over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fix_field_decoder;
    import fix_pkg::*;

    localparam int TAG_W   = 16;
    localparam int MAX_VAL = 32;
    localparam int LEN_W   = 6;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [LEN_W-1:0]     len;
        logic [8*MAX_VAL-1:0] val;
        logic [2:0]           err;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic        tag_s_i = 1'b0, tag_e_i = 1'b0, value_s_i = 1'b0, value_e_i = 1'b0;
    logic [15:0] drop_cnt_o;

    fix_field_decoder_if #(.TAG_W(TAG_W), .MAX_VAL(MAX_VAL), .LEN_W(LEN_W)) fld_if ();

    fix_field_decoder #(.TAG_W(TAG_W), .MAX_VAL(MAX_VAL), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .tag_s_i    (tag_s_i),
        .tag_e_i    (tag_e_i),
        .value_s_i  (value_s_i),
        .value_e_i  (value_e_i),
        .fld        (fld_if),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    rec_t exp_q[$];
    rec_t mon_got, mon_exp;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   exp_drop = 0;

    function automatic rec_t cur_rec();
        return {fld_if.fld_tag_o, fld_if.fld_len_o, fld_if.fld_val_o, fld_if.fld_err_o};
    endfunction

    // Scoreboard: every accepted record is popped against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && fld_if.fld_valid_o === 1'b1 && fld_if.fld_ready_i === 1'b1) begin
            mon_got = cur_rec();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL record_unexpected: got tag=%0d len=%0d err=%b, required no record",
                         mon_got.tag, mon_got.len, mon_got.err);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL record: got tag=%0d len=%0d err=%b val=%h, required tag=%0d len=%0d err=%b val=%h",
                             mon_got.tag, mon_got.len, mon_got.err, mon_got.val,
                             mon_exp.tag, mon_exp.len, mon_exp.err, mon_exp.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    task automatic cyc(input logic ts, input logic te, input logic vs, input logic ve,
                       input logic [7:0] d);
        tag_s_i = ts; tag_e_i = te; value_s_i = vs; value_e_i = ve; data_i = d;
        @(posedge clk); #1;
        tag_s_i = 1'b0; tag_e_i = 1'b0; value_s_i = 1'b0; value_e_i = 1'b0; data_i = 8'h00;
    endtask

    task automatic send_tag_val(input string tg, input string vl);
        for (int i = 0; i < tg.len(); i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tg[i]);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < vl.len(); i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, vl[i]);
    endtask

    task automatic send_field(input string tg, input string vl);
        send_tag_val(tg, vl);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic push_exp(input logic [TAG_W-1:0] tag, input string vl, input logic [2:0] err);
        rec_t r;
        r.tag = tag;
        r.len = LEN_W'((vl.len() > MAX_VAL) ? MAX_VAL : vl.len());
        r.val = '0;
        for (int i = 0; i < vl.len() && i < MAX_VAL; i++) r.val[8*i +: 8] = vl[i];
        r.err = err;
        exp_q.push_back(r);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        rst = 1'b1;
        fld_if.fld_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (fld_if.fld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b, required 0", fld_if.fld_valid_o);
        end
        n_cmp++;
        if ({cur_rec(), drop_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tag=%0d len=%0d err=%b drop=%0d, required all 0",
                     fld_if.fld_tag_o, fld_if.fld_len_o, fld_if.fld_err_o, drop_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_drop = 0;
    endtask

    task automatic test_basic;
        fld_if.fld_ready_i = 1'b1;
        push_exp(16'd35, "D", 3'b000);
        send_tag_val("35", "D");
        value_e_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fld_if.fld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_valid_early: got %b during value_e cycle, required 0", fld_if.fld_valid_o);
        end
        @(posedge clk); #1;
        value_e_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o, fld_if.fld_val_o[7:0], fld_if.fld_err_o}
            !== {1'b1, 16'd35, 6'd1, 8'h44, 3'b000}) begin
            n_bad++;
            $display("FAIL basic_record: got valid=%b tag=%0d len=%0d b0=%h err=%b, required 1/35/1/44/000",
                     fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o, fld_if.fld_val_o[7:0], fld_if.fld_err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [11:0] stim [5];
        rec_t        held;
        stim = '{{4'b1000, 8'h35}, {4'b1000, 8'h36}, {4'b0100, 8'h00},
                 {4'b0010, 8'h54}, {4'b0001, 8'h00}};
        fld_if.fld_ready_i = 1'b0;
        push_exp(16'd49, "SENDER", 3'b000);
        held = exp_q[exp_q.size()-1];
        send_field("49", "SENDER");
        // "56=T" arrives while the first record is stalled; it must be dropped.
        for (int k = 0; k < 5; k++) begin
            cyc(stim[k][11], stim[k][10], stim[k][9], stim[k][8], stim[k][7:0]);
            @(negedge clk);
            n_cmp++;
            if ({fld_if.fld_valid_o, cur_rec()} !== {1'b1, held}) begin
                n_bad++;
                $display("FAIL held_stable[%0d]: got valid=%b tag=%0d len=%0d, required 1/49/6 unchanged",
                         k, fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o);
            end
        end
        exp_drop++;
        n_cmp++;
        if (drop_cnt_o !== 16'(exp_drop)) begin
            n_bad++;
            $display("FAIL backpressure_drop: got %0d, required %0d", drop_cnt_o, exp_drop);
        end
        @(posedge clk); #1;
        fld_if.fld_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (fld_if.fld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: valid got %b after accept, required 0", fld_if.fld_valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trunc;
        string s;
        s = "";
        for (int k = 0; k < MAX_VAL + 3; k++) s = $sformatf("%s%c", s, 8'h41 + k);
        fld_if.fld_ready_i = 1'b1;
        push_exp(16'd58, s, 3'b100);
        send_field("58", s);
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, fld_if.fld_len_o, fld_if.fld_err_o} !== {1'b1, 6'd32, 3'b100}) begin
            n_bad++;
            $display("FAIL trunc: got valid=%b len=%0d err=%b, required 1/32/100",
                     fld_if.fld_valid_o, fld_if.fld_len_o, fld_if.fld_err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tags;
        string            tg [4];
        logic [TAG_W-1:0] et [4];
        logic [2:0]       ee [4];
        tg = '{"99999", "65535", "3A", "A"};
        et = '{16'hFFFF, 16'd65535, 16'd3, 16'd0};
        ee = '{3'b010, 3'b000, 3'b001, 3'b001};
        fld_if.fld_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(et[i], "X", ee[i]);
            send_field(tg[i], "X");
            @(negedge clk);
            n_cmp++;
            if ({fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_err_o} !== {1'b1, et[i], ee[i]}) begin
                n_bad++;
                $display("FAIL tag_%s: got valid=%b tag=%h err=%b, required 1/%h/%b",
                         tg[i], fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_err_o, et[i], ee[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_protocol;
        fld_if.fld_ready_i = 1'b1;
        // tag_e in VAL
        send_tag_val("35", "AB");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        exp_drop++;
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, drop_cnt_o} !== {1'b0, 16'(exp_drop)}) begin
            n_bad++;
            $display("FAIL proto_tag_e_in_val: got valid=%b drop=%0d, required 0/%0d",
                     fld_if.fld_valid_o, drop_cnt_o, exp_drop);
        end
        // two strobes in one cycle
        send_tag_val("35", "AB");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h37);
        exp_drop++;
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, drop_cnt_o} !== {1'b0, 16'(exp_drop)}) begin
            n_bad++;
            $display("FAIL proto_multi_strobe: got valid=%b drop=%0d, required 0/%0d",
                     fld_if.fld_valid_o, drop_cnt_o, exp_drop);
        end
        // lone tag byte in VAL: drop and start the new tag with that byte
        send_tag_val("35", "AB");
        exp_drop++;
        push_exp(16'd9, "Q", 3'b000);
        send_field("9", "Q");
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, fld_if.fld_tag_o, drop_cnt_o} !== {1'b1, 16'd9, 16'(exp_drop)}) begin
            n_bad++;
            $display("FAIL proto_restart: got valid=%b tag=%0d drop=%0d, required 1/9/%0d",
                     fld_if.fld_valid_o, fld_if.fld_tag_o, drop_cnt_o, exp_drop);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        fld_if.fld_ready_i = 1'b1;
        push_exp(16'd1, "A", 3'b000);
        push_exp(16'd22, "BB", 3'b000);
        push_exp(16'd333, "CCC", 3'b000);
        send_field("1", "A");
        send_field("22", "BB");
        send_field("333", "CCC");
        @(posedge clk); #1;
        // Commit coinciding with acceptance: valid must stay high with the new record.
        fld_if.fld_ready_i = 1'b0;
        push_exp(16'd4, "D", 3'b000);
        send_field("4", "D");
        push_exp(16'd5, "E", 3'b000);
        send_tag_val("5", "E");
        value_e_i = 1'b1;
        fld_if.fld_ready_i = 1'b1;
        @(posedge clk); #1;
        value_e_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, fld_if.fld_tag_o} !== {1'b1, 16'd5}) begin
            n_bad++;
            $display("FAIL b2b_commit_on_accept: got valid=%b tag=%0d, required 1/5",
                     fld_if.fld_valid_o, fld_if.fld_tag_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (fld_if.fld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: valid got %b, required 0", fld_if.fld_valid_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_field;
        fld_if.fld_ready_i = 1'b1;
        send_tag_val("12", "AB");
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, cur_rec(), drop_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got valid=%b tag=%0d len=%0d err=%b drop=%0d, required all 0",
                     fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o, fld_if.fld_err_o, drop_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_drop = 0;
        push_exp(16'd8, "FIX", 3'b000);
        send_field("8", "FIX");
        @(negedge clk);
        n_cmp++;
        if ({fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o, drop_cnt_o} !== {1'b1, 16'd8, 6'd3, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_recover: got valid=%b tag=%0d len=%0d drop=%0d, required 1/8/3/0",
                     fld_if.fld_valid_o, fld_if.fld_tag_o, fld_if.fld_len_o, drop_cnt_o);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        fld_if.fld_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_trunc();
        test_tags();
        test_protocol();
        test_back_to_back();
        test_reset_mid_field();
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL records_outstanding: got %0d unreturned, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fix_field_decoder.md
# fix_field_decoder

Downstream consumer of the FIX byte parser. Takes the parser's byte stream and its tag/value strobes, converts each ASCII decimal tag into a binary tag number, and captures the value bytes. Each completed field is presented as one record on a valid/ready output. Sits between the parser and the message-level logic (session/checksum/order handling).

## Interface
Parameters:
- TAG_W, 16, width of binary tag number
- MAX_VAL, 32, max stored value bytes per field
- LEN_W, 6, width of length field; must satisfy 2**LEN_W > MAX_VAL

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- data_i  in  8  byte from parser
- tag_s_i  in  1  data_i is a tag byte
- tag_e_i  in  1  one-cycle pulse on '=' (data_i ignored)
- value_s_i  in  1  data_i is a value byte
- value_e_i  in  1  one-cycle pulse on SOH (data_i ignored)
- fld_valid_o  out  1  field record valid
- fld_ready_i  in  1  consumer accepts record
- fld_tag_o  out  TAG_W  binary tag number
- fld_len_o  out  LEN_W  stored value byte count, 0..MAX_VAL
- fld_val_o  out  8*MAX_VAL  value bytes; byte k at bits [8k+7:8k], unused bytes zero
- fld_err_o  out  3  {trunc, tag_ovf, bad_tag}
- drop_cnt_o  out  16  saturating count of discarded fields

## Operation
- FSM states IDLE, TAG, VAL. One byte per cycle max.
- IDLE: tag_s_i -> clear accumulators, accumulate byte, go TAG. tag_e_i, value_s_i, value_e_i -> protocol error, stay IDLE.
- TAG: tag_s_i -> accumulate. tag_e_i -> VAL; if zero tag digits were seen, set bad_tag.
- VAL: value_s_i -> store byte at index len, len+1. value_e_i -> commit, go IDLE.
- Tag accumulate: tag = tag*10 + (byte-0x30). A byte outside 0x30..0x39 sets bad_tag; tag is not updated.
- Tag overflow: a result above 2**TAG_W-1 sets tag_ovf; tag saturates at all-ones.
- Value bytes beyond MAX_VAL are discarded and set trunc; len stays at MAX_VAL.
- Protocol error: any strobe illegal in the current state, or more than one strobe in a cycle. Discard the partial field, increment drop_cnt_o, go IDLE. Exception: tag_s_i alone while in VAL discards and also starts a new tag (go TAG with that byte).
- Fields with bad_tag, tag_ovf, or trunc are committed with flags set, not dropped.
- Buffering: the assembly buffer and output register are separate. Commit loads the output register if it is empty, or if it is being accepted in the same cycle (valid & ready).
- If the output register is full and not accepted, the committed field is dropped and drop_cnt_o increments.
- drop_cnt_o saturates at 0xFFFF.

## Timing
- Reset: fld_valid_o=0; fld_tag_o, fld_len_o, fld_val_o, fld_err_o, drop_cnt_o = 0; FSM IDLE; accumulators cleared. Reset mid-field discards that field without incrementing drop_cnt_o.
- Latency: fld_valid_o rises the cycle after the value_e_i cycle.
- Handshake: fld_valid_o stays high and all fld_* outputs stay stable until the fld_ready_i cycle. fld_valid_o deasserts the next cycle unless a commit coincides, in which case the new record appears with valid held high.
- fld_ready_i may be high while fld_valid_o is low; no effect.
- Back-to-back fields: a new tag byte may arrive the cycle after value_e_i. Assembly continues regardless of output backpressure.
- drop_cnt_o updates one cycle after the drop event.

## Structure
- fix_pkg: SOH_C=0x01, SEP_C=0x3D, ZERO_C=0x30, NINE_C=0x39; FSM state enum; error bit index constants. Shared with fix_parser.
- Sub-module fix_tag_accum: decimal digit accumulator with saturation, bad-digit flag, and digit count; clear/enable inputs.
- Top level contains the FSM, value buffer, output register, and drop counter.

## Test plan
- Parser stream for "35=D" then SOH -> one record: tag 35, len 1, val[7:0]=0x44, err 0, valid the cycle after value_e_i.
- "49=SENDER" with fld_ready_i low for 5 cycles, then "56=T" -> first record held stable; second field dropped; drop_cnt_o=1; after ready, the first record is accepted.
- Value of MAX_VAL+3 bytes -> len=MAX_VAL, trunc=1, bytes MAX_VAL..MAX_VAL+2 absent.
- Tag "99999" with TAG_W=16 -> tag 0xFFFF, tag_ovf=1. Tag "3A" -> bad_tag=1, tag 3. tag_e_i with no digits -> bad_tag=1, tag 0.
- tag_e_i while in VAL, and tag_s_i with value_s_i in the same cycle -> each discards the field; drop_cnt_o increments by 1 per event; no record emitted.
- rst asserted mid-value, then "8=FIX" -> all outputs 0 after reset, drop_cnt_o=0, then one correct record for tag 8.
